// File: rtl/diff_link_pkg.sv
// Shared definitions for the differential serial link (diff_tx_queue, diff_rx).
package diff_link_pkg;

    localparam int CODE_WIDTH_DEF = 26;
    // The start symbol is a steady high lasting this many bit periods
    localparam int START_PERIODS = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BITS,
        GAP
    } link_state_t;

endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO with occupancy count; write side is a valid/ready handshake.
module code_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CNW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Ready depends only on the registered count, so a pop never frees a slot same-cycle
    assign wr_ready = (count < CNW'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_en && (count != '0);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNW'(1);
                2'b01:   count <= count - CNW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/diff_tx_queue.sv
// Queued differential-Manchester transmitter: FIFO of codes, framed back-to-back with a gap.
// Define DIFF_TX_PARITY_EN to append an even-parity bit period after the payload.
module diff_tx_queue
    import diff_link_pkg::*;
#(
    parameter int CODE_WIDTH  = CODE_WIDTH_DEF,
    parameter int DATA_PERIOD = 20,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_PERIODS = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [CODE_WIDTH-1:0]         data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          data_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out,
    output logic                          overflow_out
);
`ifdef DIFF_TX_PARITY_EN
    localparam int NBITS = CODE_WIDTH + 1;
`else
    localparam int NBITS = CODE_WIDTH;
`endif
    localparam int HALF  = DATA_PERIOD / 2;
    localparam int PCW   = $clog2(DATA_PERIOD);
    localparam int BCW_A = $clog2(CODE_WIDTH + 1);
    localparam int BCW_B = $clog2(GAP_PERIODS + 1);
    localparam int BCW   = (BCW_A > BCW_B) ? BCW_A : BCW_B;

    localparam logic [PCW-1:0] PER_LAST   = PCW'(DATA_PERIOD - 1);
    localparam logic [PCW-1:0] PER_HALF   = PCW'(HALF);
    localparam logic [BCW-1:0] START_LAST = BCW'(START_PERIODS - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(NBITS - 1);
    localparam logic [BCW-1:0] GAP_LAST   = BCW'(GAP_PERIODS - 1);

    link_state_t             state;
    link_state_t             state_nxt;
    logic [PCW-1:0]          per_cnt;
    logic [BCW-1:0]          bit_cnt;
    logic [CODE_WIDTH-1:0]   shreg;
    logic                    fill_bit;
    logic                    period_end;
    logic                    line_nxt;
    logic                    pop;
    logic [CODE_WIDTH-1:0]   fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    code_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .wr_data  (data_in),
        .wr_valid (valid_in),
        .wr_ready (ready_out),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign count_out    = fifo_count;
    assign overflow_out = valid_in && !ready_out;
    assign busy_out     = (state != IDLE);
    assign period_end   = (per_cnt == PER_LAST);

`ifdef DIFF_TX_PARITY_EN
    // Parity rides in behind the payload so it reaches the MSB after CODE_WIDTH shifts
    logic par_q;
    assign fill_bit = par_q;
    always_ff @(posedge clk_in) begin
        if (pop) par_q <= ^fifo_rd_data;
    end
`else
    assign fill_bit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        line_nxt  = data_out;
        case (state)
            IDLE: begin
                line_nxt = 1'b0;
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                line_nxt = 1'b1;
                if (period_end && (bit_cnt == START_LAST)) state_nxt = BITS;
            end
            BITS: begin
                if (per_cnt == '0)
                    line_nxt = ~data_out;
                else if ((per_cnt == PER_HALF) && shreg[CODE_WIDTH-1])
                    line_nxt = ~data_out;
                if (period_end && (bit_cnt == BIT_LAST)) state_nxt = GAP;
            end
            GAP: begin
                line_nxt = 1'b0;
                if (period_end && (bit_cnt == GAP_LAST)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The line register follows the state by one cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            per_cnt  <= '0;
            bit_cnt  <= '0;
            data_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            data_out <= line_nxt;
            if (state == IDLE || period_end) per_cnt <= '0;
            else                             per_cnt <= per_cnt + PCW'(1);
            if (state != state_nxt) bit_cnt <= '0;
            else if (period_end)    bit_cnt <= bit_cnt + BCW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (pop)
            shreg <= fifo_rd_data;
        else if (state == BITS && period_end)
            shreg <= {shreg[CODE_WIDTH-2:0], fill_bit};
    end

endmodule

// File: tb/tb_diff_tx_queue.sv
// Randomised bench for diff_tx_queue against a frame-level waveform model.
module tb_diff_tx_queue;
    localparam int CW    = 26;
    localparam int DP    = 20;
    localparam int HALF  = DP / 2;
    localparam int DEPTH = 4;
    localparam int GAPP  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] din = '0;
    logic          vin = 1'b0;
    logic          ready_out, data_out, busy_out, overflow_out;
    logic [2:0]    count_out;

    int n_chk = 0;
    int n_bad = 0;
    bit armed = 0;

    logic [CW-1:0] mq[$];
    bit            wave[$];
    bit            exp_line = 0;

    always #5 clk = ~clk;

    diff_tx_queue dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .data_in      (din),
        .valid_in     (vin),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .busy_out     (busy_out),
        .count_out    (count_out),
        .overflow_out (overflow_out)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d want %0d", tag, $time, act, exp);
        end
    endtask

    // Whole frame as line levels, one entry per clock: start, payload (+parity), gap
    task automatic build_frame(input logic [CW-1:0] code);
        bit lvl;
        bit b;
        int nb;
        lvl = 1;
        for (int c = 0; c < DP; c++) wave.push_back(1'b1);
`ifdef DIFF_TX_PARITY_EN
        nb = CW + 1;
`else
        nb = CW;
`endif
        for (int i = 0; i < nb; i++) begin
            b = (i < CW) ? code[CW-1-i] : ^code;
            for (int c = 0; c < DP; c++) begin
                if (c == 0) lvl = !lvl;
                if (c == HALF && b) lvl = !lvl;
                wave.push_back(lvl);
            end
        end
        for (int c = 0; c < GAPP * DP; c++) wave.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit idle;
        int pre;
        if (rst) begin
            mq.delete();
            wave.delete();
            exp_line = 0;
            return;
        end
        idle = (wave.size() == 0);
        exp_line = idle ? 1'b0 : wave.pop_front();
        pre = mq.size();
        if (idle && pre > 0) build_frame(mq.pop_front());
        if (vin && pre < DEPTH) mq.push_back(din);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [CW-1:0] d);
        @(negedge clk);
        rst = r;
        vin = v;
        din = d;
        #1;
        if (armed) begin
            chk("line",  32'(data_out),     32'(exp_line));
            chk("busy",  32'(busy_out),     32'(wave.size() != 0));
            chk("count", 32'(count_out),    32'(mq.size()));
            chk("ready", 32'(ready_out),    32'(mq.size() < DEPTH));
            chk("ovf",   32'(overflow_out), 32'(v && mq.size() >= DEPTH));
        end
        @(posedge clk);
        model_edge();
        if (r) armed = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, CW'($urandom));
    endtask

    initial begin
        logic [CW-1:0] alt;
        logic          rv, vv;
        alt = 26'b10101010101010101010101010;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
        run(2);

        cycle(1'b0, 1'b1, 26'b00101111100011001000011001);
        run(700);

        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '1);
        run(1400);

        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, CW'($urandom));
        run(3300);

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, CW'($urandom));
        run(60);
        cycle(1'b1, 1'b0, '0);
        run(700);

        cycle(1'b0, 1'b1, CW'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, alt);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, CW'($urandom));
        run(3300);

        for (int i = 0; i < 8000; i++) begin
            vv = ($urandom_range(0, 199) == 0);
            rv = ($urandom_range(0, 4999) == 0);
            cycle(rv, vv, CW'($urandom));
        end
        run(700);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
